// File: rtl/stack_arb_pkg.sv
// Shared types and default sizes for the two-client stack arbiter and the stack it fronts.
package stack_arb_pkg;

    localparam int DEPTH = 5;
    localparam int DW    = 4;
    localparam int IW    = 3;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_PUSH = 2'd1,
        CMD_POP  = 2'd2,
        CMD_GET  = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/stack_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant among unmasked requests, last-served
// pointer advanced only when the FSM actually takes the grant.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    input  logic [1:0] mask_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic       last_q, last_d;
    logic [1:0] elig;

    always_comb begin
        elig   = req_i & ~mask_i;
        gnt_o  = elig;
        if (elig == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (adv_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end
    end

    // Pointer starts as "client 1 served last" so client 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one stack between two clients: round-robin grant, fixed 3-cycle
// IDLE/ISSUE/RESP handshake, and shadow-count based overflow/underflow/range protection.
module stack_arbiter #(
    parameter int DEPTH = stack_arb_pkg::DEPTH,
    parameter int DW    = stack_arb_pkg::DW,
    parameter int IW    = stack_arb_pkg::IW,
    parameter int CW    = 3
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic [1:0]    CMD0,
    input  logic [1:0]    CMD1,
    input  logic [IW-1:0] IDX0,
    input  logic [IW-1:0] IDX1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic          ERR,
    output logic [DW-1:0] RDATA,
    output logic [CW-1:0] COUNT,
    output logic [1:0]    S_COMMAND,
    output logic [IW-1:0] S_INDEX,
    output logic [DW-1:0] S_IDATA,
    output logic          S_RESET,
    input  logic [DW-1:0] S_ODATA
);

    import stack_arb_pkg::*;

    localparam int MW = (IW > CW) ? IW : CW;

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d, scmd_q, scmd_d, sel_cmd;
    logic [IW-1:0] idx_q, idx_d, sel_idx;
    logic [DW-1:0] wdata_q, wdata_d, sel_wdata;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [CW-1:0] count_q, count_d;
    logic          gid_q, gid_d, bad_q, bad_d;
    logic          err_q, err_d, ack0_q, ack0_d, ack1_q, ack1_d;
    logic          srst_q, adv, legal;
    logic [1:0]    gnt;

    function automatic logic cmd_legal(cmd_t c, logic [IW-1:0] idx, logic [CW-1:0] cnt);
        case (c)
            CMD_PUSH: return cnt != CW'(DEPTH);
            CMD_POP:  return cnt != '0;
            CMD_GET:  return MW'(idx) < MW'(cnt);
            default:  return 1'b1;
        endcase
    endfunction

    rr_arbiter2 u_arb (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .req_i  ({REQ1, REQ0}),
        .mask_i ({ack1_q, ack0_q}),
        .adv_i  (adv),
        .gnt_o  (gnt)
    );

    always_comb begin
        sel_cmd   = gnt[1] ? cmd_t'(CMD1) : cmd_t'(CMD0);
        sel_idx   = gnt[1] ? IDX1 : IDX0;
        sel_wdata = gnt[1] ? WDATA1 : WDATA0;
        legal     = cmd_legal(sel_cmd, sel_idx, count_q);
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        gid_d   = gid_q;
        bad_d   = bad_q;
        scmd_d  = CMD_NOP;
        count_d = count_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = err_q;
        rdata_d = rdata_q;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // No arbitration while the stack is still held in reset.
                if (!srst_q && (gnt != 2'b00)) begin
                    adv     = 1'b1;
                    gid_d   = gnt[1];
                    cmd_d   = sel_cmd;
                    idx_d   = sel_idx;
                    wdata_d = sel_wdata;
                    bad_d   = !legal;
                    if (legal) begin
                        scmd_d = sel_cmd;
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bad_q && cmd_q == CMD_PUSH) count_d = count_q + CW'(1);
                if (!bad_q && cmd_q == CMD_POP)  count_d = count_q - CW'(1);
                state_d = ST_RESP;
            end
            ST_RESP: begin
                ack0_d  = !gid_q;
                ack1_d  = gid_q;
                err_d   = bad_q;
                rdata_d = (!bad_q && (cmd_q == CMD_POP || cmd_q == CMD_GET)) ? S_ODATA : '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            idx_q   <= '0;
            wdata_q <= '0;
            gid_q   <= 1'b0;
            bad_q   <= 1'b0;
            scmd_q  <= CMD_NOP;
            count_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            gid_q   <= gid_d;
            bad_q   <= bad_d;
            scmd_q  <= scmd_d;
            count_q <= count_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Stack reset asserts with RESET and releases one edge later.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            srst_q <= 1'b1;
        end else begin
            srst_q <= 1'b0;
        end
    end

    assign ACK0      = ack0_q;
    assign ACK1      = ack1_q;
    assign ERR       = err_q;
    assign RDATA     = rdata_q;
    assign COUNT     = count_q;
    assign S_COMMAND = scmd_q;
    assign S_INDEX   = idx_q;
    assign S_IDATA   = wdata_q;
    assign S_RESET   = srst_q;

endmodule

// File: doc/stack_arbiter.md
# stack_arbiter

Shares one `stack_behaviour_easy` instance between two requesters: round-robin arbitration, a uniform request/acknowledge handshake, and protection of the stack against overflow, underflow and out-of-range reads. It sits between two client blocks and the stack, drives all stack command inputs, and returns stack read data to the granted client. A shadow occupancy counter gives clients the current depth without a stack access.

## Interface
- DEPTH, 5: stack capacity; legal GET index range is 0..COUNT-1.
- DW, 4: data width; matches stack I_DATA/O_DATA.
- IW, 3: index width; matches stack INDEX.
- CW, 3: COUNT width; must hold 0..DEPTH.

- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low.
- REQ0, REQ1  in  1  client request, held until ACK.
- CMD0, CMD1  in  2  0 NOP, 1 PUSH, 2 POP, 3 GET.
- IDX0, IDX1  in  IW  GET index, 0 = top.
- WDATA0, WDATA1  in  DW  PUSH data.
- ACK0, ACK1  out  1  one-cycle completion pulse.
- ERR  out  1  valid with ACK; 1 = rejected, stack untouched.
- RDATA  out  DW  valid with ACK.
- COUNT  out  CW  shadow occupancy.
- S_COMMAND  out  2  to stack COMMAND.
- S_INDEX  out  IW  to stack INDEX.
- S_IDATA  out  DW  to stack I_DATA.
- S_RESET  out  1  to stack RESET, active-high.
- S_ODATA  in  DW  from stack O_DATA.

## Operation
- FSM: IDLE -> ISSUE -> RESP -> IDLE. Every accepted request takes exactly this path, including NOP and rejected requests.
- IDLE: arbitrate among the unmasked REQ lines. Latch the winner's CMD, IDX and WDATA plus the grant id, then go to ISSUE. With no request, stay in IDLE.
- Round-robin: if both clients request, grant the one not served last. A single requester always wins. The pointer resets to "client 1 served last", so client 0 wins the first tie.
- Legality is decided in IDLE from COUNT:
  - PUSH is illegal when COUNT==DEPTH.
  - POP is illegal when COUNT==0.
  - GET is illegal when IDX>=COUNT.
- ISSUE:
  - A legal PUSH, POP or GET drives S_COMMAND=cmd, S_INDEX=IDX and S_IDATA=WDATA from registers for this one cycle. The stack samples at the end of the cycle.
  - NOP or an illegal request drives S_COMMAND=0.
  - COUNT changes at the end of ISSUE: +1 on a legal PUSH, -1 on a legal POP.
- RESP:
  - S_COMMAND=0.
  - RDATA is loaded with S_ODATA for a legal POP or GET, and with 0 otherwise.
  - ERR is loaded with 1 for an illegal request, 0 otherwise.
  - ACK of the granted client is set.
- ACKn, ERR and RDATA are registers. ACK is high for exactly the cycle after RESP, which is an IDLE cycle. ERR and RDATA hold until the next ACK.
- In the ACK cycle the acknowledged client's REQ is masked. The other client may be granted in that same cycle.
- S_COMMAND is 0 in every cycle except ISSUE.

## Timing
- Latency: REQ sampled in IDLE at cycle t; stack command in cycle t+1; ACK in cycle t+3. This is the same for all commands and for errors.
- Throughput: one transaction per 3 cycles. Back-to-back transactions from alternating clients have no extra bubble.
- Reset values: ACK0=ACK1=0, ERR=0, RDATA=0, COUNT=0, S_COMMAND=0, S_INDEX=0, S_IDATA=0, FSM=IDLE.
- S_RESET timing: high while RESET is low, and for one CLK cycle after RESET deasserts (single-register synchronous release). The FSM does not arbitrate in that cycle.
- Reset during ISSUE or RESP: the transaction is dropped with no ACK, and COUNT returns to 0 consistently with the stack clear.
- REQ dropped before ACK is a protocol violation. Behaviour is undefined and is not checked.

## Structure
- Package `stack_arb_pkg` holds:
  - the `cmd_t` enum (NOP=0, PUSH=1, POP=2, GET=3);
  - the `state_t` enum (IDLE, ISSUE, RESP);
  - default constants DEPTH, DW and IW, shared with the stack bench.
- Sub-module `rr_arbiter2`: two requests and two masks in, one-hot grant out. It holds the last-served pointer and updates it on an advance strobe from the FSM in IDLE.
- The top level contains the FSM, request latches, COUNT, the S_RESET synchroniser and the output registers.

## Test plan
- Reset then single client: RESET low for 2 cycles with REQ0 held on PUSH 7.
  - S_RESET stays high for one cycle after release.
  - S_COMMAND=1 with S_IDATA=7 in cycle t+1.
  - ACK0 in cycle t+3 with ERR=0 and COUNT=1.
- Fill and overflow: client 0 pushes 1..5, then pushes 6.
  - After the five pushes COUNT=5.
  - The sixth push returns ERR=1, S_COMMAND stays 0 throughout it, and COUNT stays 5.
  - A following GET IDX 0 returns RDATA=5.
- Underflow: from reset, POP.
  - ACK with ERR=1, RDATA=0, COUNT=0, and no stack command.
- GET range: stack holds 1,2,3 (top 3).
  - GET 2 returns 1.
  - GET 3 returns ERR=1.
- Contention: REQ0 PUSH 4 and REQ1 PUSH 9 raised in the same cycle.
  - Client 0 is issued first and ACK0 fires.
  - Client 1 is issued from the ACK0 cycle and ACK1 fires 3 cycles later.
  - A repeated tie then grants client 0, because client 1 was served last.
- Mid-transaction reset: RESET pulled low during ISSUE of a PUSH.
  - No ACK.
  - COUNT=0.
  - S_RESET high.
  - A subsequent GET 0 returns ERR=1.
